// File: rtl/muldiv_dispatch.sv
// Multiply/divide dispatcher: MUL-class ops go to an external 1-cycle multiplier,
// DIV-class ops run a 32-step restoring divider. Define MULDIV_DIV_ZERO_FAST_EN for early divide-by-zero.
module muldiv_dispatch #(
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_MULOP = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_vld,
  output logic               op_rdy,
  input  logic [W_MULOP-1:0] op,
  input  logic [W_DATA-1:0]  op_a,
  input  logic [W_DATA-1:0]  op_b,
  input  logic               op_kill,
  output logic               mul_op_vld,
  output logic [W_MULOP-1:0] mul_op,
  output logic [W_DATA-1:0]  mul_op_a,
  output logic [W_DATA-1:0]  mul_op_b,
  input  logic [W_DATA-1:0]  mul_result,
  input  logic               mul_result_vld,
  output logic [W_DATA-1:0]  result,
  output logic               result_vld
);

  localparam int unsigned W_CNT = $clog2(W_DATA);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFin  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic [W_DATA-1:0] quo_q, quo_d;    // dividend shifting out, quotient shifting in
  logic [W_DATA-1:0] rem_q, rem_d;
  logic [W_DATA-1:0] dvsr_q, dvsr_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic [W_DATA-1:0] result_q, result_d;

  logic              kill_act;
  logic              accept;
  logic              is_div_op;
  logic              is_signed;
  logic              sign_a, sign_b;
  logic [W_DATA-1:0] abs_a, abs_b;
  logic [W_DATA:0]   shifted, trial;
  logic [W_DATA-1:0] fin_val;

  assign kill_act  = op_kill && (state_q != StIdle);
  assign op_rdy    = ((state_q == StIdle) || (state_q == StMul)) && !kill_act;
  assign accept    = op_vld && op_rdy;
  assign is_div_op = (op >= W_MULOP'(4));
  assign is_signed = !op[0];

  assign mul_op_vld = accept && !is_div_op;
  assign mul_op     = op;
  assign mul_op_a   = op_a;
  assign mul_op_b   = op_b;

  assign sign_a = is_signed && op_a[W_DATA-1];
  assign sign_b = is_signed && op_b[W_DATA-1];
  assign abs_a  = sign_a ? (~op_a + W_DATA'(1)) : op_a;
  assign abs_b  = sign_b ? (~op_b + W_DATA'(1)) : op_b;

  // Partial remainder stays below the divisor, so one extra bit holds the trial.
  assign shifted = {rem_q, quo_q[W_DATA-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_comb begin
    fin_val = '0;
    if (is_rem_q) begin
      fin_val = neg_rem_q ? (~rem_q + W_DATA'(1)) : rem_q;
    end else begin
      fin_val = neg_quo_q ? (~quo_q + W_DATA'(1)) : quo_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;
    case (state_q)
      StIdle, StMul: begin
        if (state_q == StMul && mul_result_vld && !kill_act) begin
          result_d = mul_result;
        end
        if (accept) begin
          if (!is_div_op) begin
            state_d = StMul;
          end else begin
            state_d   = StDiv;
            cnt_d     = '0;
            quo_d     = abs_a;
            rem_d     = '0;
            dvsr_d    = abs_b;
            neg_quo_d = (sign_a != sign_b) && (op_b != '0);
            neg_rem_d = sign_a;
            is_rem_d  = op[1];
`ifdef MULDIV_DIV_ZERO_FAST_EN
            if (op_b == '0) begin
              state_d   = StFin;
              quo_d     = '1;
              rem_d     = op_a;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
            end
`endif
          end
        end else begin
          state_d = StIdle;
        end
      end
      StDiv: begin
        cnt_d = cnt_q + W_CNT'(1);
        if (!trial[W_DATA]) begin
          rem_d = trial[W_DATA-1:0];
          quo_d = {quo_q[W_DATA-2:0], 1'b1};
        end else begin
          rem_d = shifted[W_DATA-1:0];
          quo_d = {quo_q[W_DATA-2:0], 1'b0};
        end
        if (cnt_q == W_CNT'(W_DATA - 1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        if (!kill_act) begin
          result_d = fin_val;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (kill_act) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    result_vld = 1'b0;
    result     = result_q;
    if (state_q == StMul) begin
      result     = mul_result;
      result_vld = mul_result_vld && !op_kill;
    end else if (state_q == StFin) begin
      result     = fin_val;
      result_vld = !op_kill;
    end
  end

endmodule

// File: doc/muldiv_dispatch.md
MULDIV_DISPATCH -- requirements
Module: muldiv_dispatch

Interface
REQ-001 Parameter W_DATA, default 32: operand/result width.
REQ-002 Parameter W_MULOP, default 3: opcode width; encodings MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_vld  input  1  upstream offers an operation.
REQ-006 op_rdy  output  1  block accepts; transfer when op_vld && op_rdy.
REQ-007 op  input  W_MULOP  opcode.
REQ-008 op_a, op_b  input  W_DATA each  operands (rs1, rs2).
REQ-009 op_kill  input  1  abort any in-flight operation.
REQ-010 mul_op_vld  output  1  issue to fast multiplier.
REQ-011 mul_op  output  W_MULOP; mul_op_a, mul_op_b  output  W_DATA each  multiplier operands.
REQ-012 mul_result  input  W_DATA; mul_result_vld  input  1  multiplier return, latency 1.
REQ-013 result  output  W_DATA  final result; result_vld  output  1  one-cycle valid strobe.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, FIN.
REQ-015 op_rdy SHALL be 1 in IDLE and MUL, 0 in DIV and FIN.
REQ-016 Accept of op<4: mul_op_vld=1 in the accept cycle (combinational), mul_op/mul_op_a/mul_op_b = op/op_a/op_b; next state MUL.
REQ-017 In MUL: result=mul_result, result_vld=mul_result_vld; next state MUL if a new MUL-class op accepted, DIV if a DIV-class op accepted, else IDLE (back-to-back MUL, one per cycle).
REQ-018 Accept of op>=4: latch operands, absolute values for DIV/REM, record signs; 5-bit counter=0; next state DIV.
REQ-019 DIV: one restoring radix-2 step per cycle on W_DATA-bit unsigned magnitudes; after 32 steps go FIN.
REQ-020 FIN: result_vld=1; result=quotient (DIV/DIVU) or remainder (REM/REMU); next IDLE.
REQ-021 Signed correction: quotient negated iff sign(a)!=sign(b) and b!=0; remainder takes sign of a.
REQ-022 Divide by zero: quotient=all ones, remainder=op_a (all four ops).
REQ-023 Overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-024 Latency: MUL-class accepted cycle T -> result_vld at T+1; DIV-class -> result_vld at T+33.
REQ-025 op_kill in MUL, DIV or FIN: result_vld forced 0 that cycle, state to IDLE next cycle; a new op offered in the same cycle is not accepted.
REQ-026 op_kill in IDLE SHALL have no effect.
REQ-027 result SHALL hold its last value when result_vld=0 outside MUL.

Reset
REQ-028 On rst_n low: state=IDLE, counter=0, result_vld=0, mul_op_vld=0, result=0, all datapath registers=0.
REQ-029 Reset mid-division discards the operation; op_rdy=1 from first clock after release.

Configuration
REQ-030 Macro MULDIV_DIV_ZERO_FAST_EN: when defined, a DIV-class accept with op_b=0 goes directly to FIN, result_vld at T+1 with REQ-022 values; when undefined, full 33-cycle path with identical values.

Verification
REQ-031 MUL 7*6 accepted T -> mul_op_vld at T, result=42, result_vld at T+1.
REQ-032 Back-to-back MULHU 0xFFFFFFFF*2 then MUL 3*3 -> result 0x00000001 at T+1, 9 at T+2, op_rdy stays 1.
REQ-033 DIV -7/2 -> result 0xFFFFFFFD at T+33; REM -7/2 -> 0xFFFFFFFF.
REQ-034 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; T+33 without macro, T+1 with.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+33.
REQ-036 DIVU 100/3, op_kill at T+10 -> no result_vld, op_rdy=1 at T+11; next DIVU 9/3 -> 3 at 33 cycles after its accept.
